imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer end of the instruction-memory interface: the processor only ever reads instruction memory, and this block fills it.
- Accepts a byte stream over a valid/ready handshake (UART/JTAG bridge side) and assembles little-endian 32-bit words.
- Writes each word into instruction memory at consecutive word addresses.
- Holds the processor in reset until a complete program has been written.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- DEPTH, 2**ADDR_W, number of writable words; a header count above this is an error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts the byte; transfer occurs when rx_valid&&rx_ready.
- imem_we  out  1  instruction-memory write strobe, exactly one cycle per word.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  word being written.
- cpu_hold  out  1  1 = processor held in reset; drives the processor's reset.
- busy  out  1  load in progress (HDR, DATA or WRITE).
- done  out  1  level; program loaded.
- error  out  1  level; header count exceeded DEPTH.
- words_loaded  out  ADDR_W+1  count of words written in the current load.

Behaviour:
- Reset (reset=0, async):
  - State = IDLE.
  - rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_hold=1, busy=0, done=0, error=0, words_loaded=0.
  - Internal byte counter and word count cleared.
  - Words already written before reset are left in memory.
- States: IDLE, HDR, DATA, WRITE, DONE, ERR.
- IDLE:
  - rx_ready=0, cpu_hold=1.
  - On start: clear counters, done and error; go to HDR.
- HDR:
  - rx_ready=1.
  - Accept 4 bytes, little-endian, into a 32-bit count.
  - On the 4th handshake:
    - count==0 -> DONE.
    - count>DEPTH -> ERR.
    - otherwise -> DATA.
  - Count bits above ADDR_W+1 must be checked; nonzero upper bits -> ERR.
- DATA:
  - rx_ready=1.
  - Byte k (0..3) goes to imem_wdata[8k+7:8k].
  - On the 4th handshake -> WRITE.
- WRITE:
  - Lasts exactly one cycle; rx_ready=0.
  - imem_we=1, imem_addr = current word index, imem_wdata = assembled word.
  - Next cycle: index and words_loaded increment.
  - If the new index equals count -> DONE, else -> DATA.
  - Latency: imem_we is high in the cycle after the 4th byte handshake.
- DONE:
  - done=1, cpu_hold=0, rx_ready=0.
  - start -> HDR; cpu_hold returns to 1 in that same next cycle.
- ERR:
  - error=1, cpu_hold=1, rx_ready=0, no writes.
  - Left only by start (-> HDR) or reset.
- busy=1 exactly in HDR, DATA and WRITE; start is ignored while busy.
- Gaps in rx_valid simply stall; byte position and partial word are preserved indefinitely.
- Bytes presented while rx_ready=0 are not consumed.
- imem_addr and imem_wdata hold their last value when imem_we=0.
- imem_addr never exceeds DEPTH-1. When count==DEPTH, the last write is at DEPTH-1; the index is ADDR_W+1 bits so it reaches DEPTH without wrapping.
- All outputs are registered.

Decomposition:
- Package loader_pkg:
  - State enum (IDLE, HDR, DATA, WRITE, DONE, ERR).
  - BYTES_PER_WORD=4.
  - Byte-lane index width constant.
- Sub-module byte_assembler:
  - 2-bit byte counter plus a 32-bit little-endian shift-in register.
  - Pulses word_complete on the 4th accepted byte.
  - Shared by HDR and DATA; cleared on start.

Test Plan:
- Bytes 02 00 00 00 13 05 A0 00 93 05 B0 00 after start -> imem_we at addr0 with 0x00A00513, then at addr1 with 0x00B00593. Then done=1, cpu_hold=0, words_loaded=2.
- Same stream with rx_valid low 3 cycles between every byte -> identical writes; each imem_we lasts exactly 1 cycle; no byte is lost or duplicated.
- Header 00 00 00 00 -> DONE after the 4th byte, no imem_we, cpu_hold=0, words_loaded=0.
- Header 01 01 00 00 (257, DEPTH=256) -> error=1, cpu_hold=1, rx_ready=0, no writes. A subsequent start with a valid 1-word stream loads successfully and clears error.
- reset pulled low after 2 data bytes of word 1 -> all outputs at reset values within the same cycle. After release and start, a fresh 1-word load writes addr0 correctly.
- start pulse during DATA -> ignored, load completes normally. start in DONE -> cpu_hold=1, done=0 next cycle; a second program overwrites from addr0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/byte_assembler.sv
// Collects four stream bytes into a little-endian word; the completing byte is
// forwarded combinationally so the caller can act on the word at that handshake.
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_complete
);

    logic [LANE_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (take) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign word_complete = take && (cnt_reg == LANE_W'(BYTES_PER_WORD - 1));

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            if (gi < BYTES_PER_WORD - 1) begin : g_reg
                logic [7:0] lane_reg;
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        lane_reg <= '0;
                    end else if (clear) begin
                        lane_reg <= '0;
                    end else if (take && cnt_reg == LANE_W'(gi)) begin
                        lane_reg <= data;
                    end
                end
                assign word[8*gi +: 8] = lane_reg;
            end else begin : g_last
                // Top lane is the byte completing the word this cycle.
                assign word[8*gi +: 8] = data;
            end
        end
    endgenerate

endmodule

// File: rtl/imem_loader.sv
// Fills instruction memory from a header-prefixed byte stream and holds the
// processor in reset until the whole program has been written.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    state_t            state_reg, state_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic [ADDR_W:0]   index_reg, index_next;
    logic              rx_ready_reg, rx_ready_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic              cpu_hold_reg, cpu_hold_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              error_reg, error_next;

    logic              take;
    logic              clear;
    logic [31:0]       word;
    logic              word_complete;

    assign take = rx_valid && rx_ready_reg;

    byte_assembler u_asm (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .take          (take),
        .data          (rx_data),
        .word          (word),
        .word_complete (word_complete)
    );

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        index_next = index_reg;
        we_next    = 1'b0;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        clear      = 1'b0;

        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    clear      = 1'b1;
                    count_next = '0;
                    index_next = '0;
                    state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                if (word_complete) begin
                    // Upper header bits must be zero, otherwise the count is out of range.
                    if ((|word[31:ADDR_W+1]) || (word[ADDR_W:0] > DEPTH_V)) begin
                        state_next = ST_ERR;
                    end else if (word[ADDR_W:0] == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        count_next = word[ADDR_W:0];
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_complete) begin
                    we_next    = 1'b1;
                    addr_next  = index_reg[ADDR_W-1:0];
                    wdata_next = word;
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                index_next = index_reg + 1'b1;
                state_next = (index_reg + 1'b1 == count_reg) ? ST_DONE : ST_DATA;
            end
            default: state_next = ST_IDLE;
        endcase

        // Status outputs are registered from the upcoming state.
        rx_ready_next = (state_next == ST_HDR) || (state_next == ST_DATA);
        busy_next     = (state_next == ST_HDR) || (state_next == ST_DATA) ||
                        (state_next == ST_WRITE);
        done_next     = (state_next == ST_DONE);
        error_next    = (state_next == ST_ERR);
        cpu_hold_next = (state_next != ST_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            index_reg    <= '0;
            rx_ready_reg <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            cpu_hold_reg <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            index_reg    <= index_next;
            rx_ready_reg <= rx_ready_next;
            we_reg       <= we_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            cpu_hold_reg <= cpu_hold_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            error_reg    <= error_next;
        end
    end

    assign rx_ready     = rx_ready_reg;
    assign imem_we      = we_reg;
    assign imem_addr    = addr_reg;
    assign imem_wdata   = wdata_reg;
    assign cpu_hold     = cpu_hold_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign error        = error_reg;
    assign words_loaded = index_reg;

endmodule
